// File: rtl/text_display_pkg.sv
// text_display_pkg: geometry, character codes, FSM encoding and byte decoder shared by the text display blocks.
//   COLS/ROWS/ADDR_W : default screen geometry and text RAM address width
//   COL_W/ROW_W      : cursor column/row widths
//   CHAR_*           : control and fill character codes
//   state_t          : writer FSM encoding
//   decodeByte()     : turns a received byte plus cursor edge flags into a write/cursor action
package text_display_pkg;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;
    localparam int COL_W  = 7;
    localparam int ROW_W  = 5;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WRITE,
        CLR_ROW,
        CLR_ALL
    } state_t;
    typedef enum logic [1:0] {
        COL_HOLD,
        COL_INC,
        COL_ZERO,
        COL_DEC
    } colOp_t;
    typedef struct packed {
        logic       write;
        logic [7:0] ch;
        colOp_t     colOp;
        logic       rowAdv;
        logic       back;
    } action_t;
    // back marks a backspace: the write lands one column left of the current cursor
    function automatic action_t decodeByte(input logic [7:0] b, input logic lastCol, input logic firstCol);
        action_t a;
        a = '0;
        a.ch = CHAR_SPACE;
        a.colOp = COL_HOLD;
        if (b >= 8'h20 && b <= 8'h7E) begin
            a.write  = 1'b1;
            a.ch     = b;
            a.colOp  = lastCol ? COL_ZERO : COL_INC;
            a.rowAdv = lastCol;
        end else if (b == CHAR_CR) begin
            a.colOp = COL_ZERO;
        end else if (b == CHAR_LF) begin
            a.rowAdv = 1'b1;
        end else if (b == CHAR_BS && !firstCol) begin
            a.write = 1'b1;
            a.colOp = COL_DEC;
            a.back  = 1'b1;
        end
        return a;
    endfunction
endpackage

// File: rtl/text_buffer_writer_cursor.sv
// text_buffer_writer_cursor: row/column cursor with a running row base address (row*COLS without a multiplier).
//   clk, rst_n        : clock, synchronous active-low reset
//   home              : force cursor to (0,0)
//   step              : apply colOp/rowAdv this cycle
//   colOp, rowAdv     : column update and row advance request
//   row, col, rowBase : cursor position and row*COLS
//   lastCol, firstCol : cursor sits in the last / first column
module text_buffer_writer_cursor #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          home,
    input  logic                          step,
    input  text_display_pkg::colOp_t      colOp,
    input  logic                          rowAdv,
    output logic [text_display_pkg::ROW_W-1:0] row,
    output logic [text_display_pkg::COL_W-1:0] col,
    output logic [ADDR_W-1:0]             rowBase,
    output logic                          lastCol,
    output logic                          firstCol
);
    import text_display_pkg::*;
    logic lastRow;
    always_comb begin
        lastCol  = col == COL_W'(COLS - 1);
        firstCol = col == '0;
        lastRow  = row == ROW_W'(ROWS - 1);
    end
    // no scrolling: advancing from the bottom row wraps to the top
    always_ff @(posedge clk) begin
        if (!rst_n || home) begin
            row     <= '0;
            col     <= '0;
            rowBase <= '0;
        end else if (step) begin
            col <= colOp == COL_INC ? col + 1'b1 : colOp == COL_DEC ? col - 1'b1 : colOp == COL_ZERO ? '0 : col;
            if (rowAdv) begin
                row     <= lastRow ? '0 : row + 1'b1;
                rowBase <= lastRow ? '0 : rowBase + ADDR_W'(COLS);
            end
        end
    end
endmodule

// File: rtl/text_buffer_writer.sv
// text_buffer_writer: drains the UART RX FIFO into the text RAM, handling CR/LF/BS, row clears and full-screen clears.
//   clk, rst_n                 : clock, synchronous active-low reset
//   fifo_empty, fifo_rd_data   : RX FIFO status and head byte (valid the cycle after a pop)
//   fifo_rd_en                 : FIFO pop strobe
//   clr_all                    : request to clear the screen and home the cursor
//   wr_en, wr_addr, wr_data    : text RAM write port
//   cur_row, cur_col           : cursor position for the renderer
//   busy                       : FSM is not idle
module text_buffer_writer #(
    parameter int COLS   = text_display_pkg::COLS,
    parameter int ROWS   = text_display_pkg::ROWS,
    parameter int ADDR_W = text_display_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [7:0]        fifo_rd_data,
    output logic              fifo_rd_en,
    input  logic              clr_all,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [4:0]        cur_row,
    output logic [6:0]        cur_col,
    output logic              busy
);
    import text_display_pkg::*;
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ALL_LAST = ADDR_W'(COLS * ROWS - 1);
    state_t            state, nextState;
    action_t           act;
    logic              clrPend, clrReq, home, step, lastCol, firstCol;
    logic [ADDR_W-1:0] rowBase, clrCnt;
    text_buffer_writer_cursor #(
        .COLS(COLS),
        .ROWS(ROWS),
        .ADDR_W(ADDR_W)
    ) u_cursor (
        .clk(clk),
        .rst_n(rst_n),
        .home(home),
        .step(step),
        .colOp(act.colOp),
        .rowAdv(act.rowAdv),
        .row(cur_row),
        .col(cur_col),
        .rowBase(rowBase),
        .lastCol(lastCol),
        .firstCol(firstCol)
    );
    always_comb begin
        act    = decodeByte(fifo_rd_data, lastCol, firstCol);
        clrReq = clr_all || clrPend;
    end
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nextState;
    end
    // The write of a fetched byte is a registered strobe that lands in the cycle after FETCH,
    // overlapping the following IDLE or first CLR_ROW cycle; this keeps a plain byte at two
    // cycles and a row-advancing byte at 2+COLS, so the WRITE code is never held in state.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = clrReq ? CLR_ALL : !fifo_empty ? FETCH : IDLE;
            FETCH:   nextState = act.rowAdv ? CLR_ROW : IDLE;
            CLR_ROW: nextState = clrCnt == ROW_LAST ? IDLE : CLR_ROW;
            CLR_ALL: nextState = clrCnt == ALL_LAST ? IDLE : CLR_ALL;
            default: nextState = IDLE;
        endcase
    end
    always_comb begin
        busy       = state != IDLE;
        fifo_rd_en = state == IDLE && !clrReq && !fifo_empty;
        home       = state == IDLE && clrReq;
        step       = state == FETCH;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
            clrCnt  <= '0;
            clrPend <= 1'b0;
        end else begin
            clrPend <= state == IDLE ? 1'b0 : clrPend || clr_all;
            case (state)
                FETCH: begin
                    wr_en   <= act.write;
                    wr_addr <= rowBase + ADDR_W'(cur_col) - ADDR_W'(act.back);
                    wr_data <= act.ch;
                    clrCnt  <= '0;
                end
                CLR_ROW: begin
                    wr_en   <= 1'b1;
                    wr_addr <= rowBase + clrCnt;
                    wr_data <= CHAR_SPACE;
                    clrCnt  <= clrCnt + 1'b1;
                end
                CLR_ALL: begin
                    wr_en   <= 1'b1;
                    wr_addr <= clrCnt;
                    wr_data <= CHAR_SPACE;
                    clrCnt  <= clrCnt + 1'b1;
                end
                default: begin
                    wr_en  <= 1'b0;
                    clrCnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_text_buffer_writer.sv
// tb_text_buffer_writer: vector table, directed corner sequences and a randomized screen model for text_buffer_writer.
module tb_text_buffer_writer;
    localparam int NC = 80;
    localparam int NR = 30;
    localparam int AW = 12;
    localparam int CELLS = NC * NR;
    typedef struct { int addr; int data; } wr_t;
    typedef struct { logic [7:0] b; int nw; int addr; int data; int row; int col; } vec_t;
    logic clk = 1'b0, rst_n = 1'b0, clr_all = 1'b0;
    logic fifo_empty, fifo_rd_en, wr_en, busy;
    logic [7:0] fifo_rd_data = 8'h00, wr_data;
    logic [AW-1:0] wr_addr;
    logic [4:0] cur_row;
    logic [6:0] cur_col;
    wr_t wq[$];
    wr_t eq[$];
    logic [7:0] ram [4096];
    logic [7:0] fifoMem [256];
    int head = 0, tail = 0, protoErr = 0, tests = 0, fails = 0;
    int scr [CELLS];
    int mrow, mcol, expW;
    vec_t tbl [14];

    always #5 clk = ~clk;
    assign fifo_empty = head == tail;

    text_buffer_writer dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .clr_all(clr_all), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
    );

    always @(posedge clk)
        if (fifo_rd_en && head != tail) begin
            fifo_rd_data <= fifoMem[head[7:0]];
            head <= head + 1;
        end

    always @(negedge clk)
        if (rst_n) begin
            if (wr_en) begin
                ram[wr_addr] <= wr_data;
                wq.push_back(wr_t'{int'(wr_addr), int'(wr_data)});
            end
            if ((fifo_rd_en && (fifo_empty || busy)) || (wr_en && int'(wr_addr) >= CELLS))
                protoErr <= protoErr + 1;
        end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifoMem[tail[7:0]] = b;
        tail++;
    endtask

    task automatic waitIdle(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 8000) begin
            @(negedge clk);
            n++;
            quiet = (!busy && fifo_empty && !wr_en) ? quiet + 1 : 0;
        end
        check({tag, "_idle"}, quiet >= 3, 1);
    endtask

    task automatic pulseClr();
        @(negedge clk);
        clr_all = 1'b1;
        @(negedge clk);
        clr_all = 1'b0;
    endtask

    task automatic addExp(input int a, input int d);
        eq.push_back(wr_t'{a, d});
    endtask

    task automatic addSpaces(input int base, input int n);
        for (int i = 0; i < n; i++) addExp(base + i, 8'h20);
    endtask

    task automatic checkSeq(input string name, input int mark);
        int bad = 0;
        check({name, "_len"}, wq.size() - mark, eq.size());
        for (int i = 0; i < eq.size(); i++)
            if (mark + i >= wq.size() || wq[mark + i].addr != eq[i].addr || wq[mark + i].data != eq[i].data) bad++;
        check({name, "_seq"}, bad, 0);
        eq.delete();
    endtask

    task automatic checkCursor(input string name, input int r, input int c);
        check({name, "_row"}, cur_row, r);
        check({name, "_col"}, cur_col, c);
    endtask

    task automatic resetChecks(input string tag);
        check({tag, "_rd_en"}, fifo_rd_en, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_busy"}, busy, 0);
        checkCursor(tag, 0, 0);
    endtask

    task automatic modelClear();
        for (int i = 0; i < CELLS; i++) scr[i] = 8'h20;
        mrow = 0;
        mcol = 0;
    endtask

    task automatic modelAdvance();
        mrow = (mrow + 1) % NR;
        for (int c = 0; c < NC; c++) scr[mrow * NC + c] = 8'h20;
        expW += NC;
    endtask

    task automatic modelByte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[mrow * NC + mcol] = b;
            expW++;
            mcol++;
            if (mcol == NC) begin
                mcol = 0;
                modelAdvance();
            end
        end else if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h0A) begin
            modelAdvance();
        end else if (b == 8'h08 && mcol > 0) begin
            mcol--;
            scr[mrow * NC + mcol] = 8'h20;
            expW++;
        end
    endtask

    initial begin
        string s;
        int m;
        tbl[0]  = '{8'h78, 1, 0, 8'h78, 0, 1};
        tbl[1]  = '{8'h08, 1, 0, 8'h20, 0, 0};
        tbl[2]  = '{8'h08, 0, 0, 0, 0, 0};
        tbl[3]  = '{8'h07, 0, 0, 0, 0, 0};
        tbl[4]  = '{8'h48, 1, 0, 8'h48, 0, 1};
        tbl[5]  = '{8'h7E, 1, 1, 8'h7E, 0, 2};
        tbl[6]  = '{8'h7F, 0, 0, 0, 0, 2};
        tbl[7]  = '{8'h1F, 0, 0, 0, 0, 2};
        tbl[8]  = '{8'h20, 1, 2, 8'h20, 0, 3};
        tbl[9]  = '{8'h0D, 0, 0, 0, 0, 0};
        tbl[10] = '{8'h0A, 80, 80, 8'h20, 1, 0};
        tbl[11] = '{8'h6B, 1, 80, 8'h6B, 1, 1};
        tbl[12] = '{8'h0D, 0, 0, 0, 1, 0};
        tbl[13] = '{8'h08, 0, 0, 0, 1, 0};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        resetChecks("reset");
        // basic text
        m = wq.size();
        s = "Hello World!";
        for (int i = 0; i < s.len(); i++) begin
            push(s[i]);
            addExp(i, s[i]);
        end
        push(8'h0D);
        push(8'h0A);
        addSpaces(80, 80);
        waitIdle("basic");
        checkSeq("basic", m);
        checkCursor("basic", 1, 0);
        check("basic_busy", busy, 0);
        // vector table from home
        pulseClr();
        waitIdle("tbl_clr");
        for (int i = 0; i < 14; i++) begin
            m = wq.size();
            push(tbl[i].b);
            waitIdle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_nw", i), wq.size() - m, tbl[i].nw);
            if (tbl[i].nw > 0 && wq.size() > m) begin
                check($sformatf("vec%0d_addr", i), wq[m].addr, tbl[i].addr);
                check($sformatf("vec%0d_data", i), wq[m].data, tbl[i].data);
            end
            checkCursor($sformatf("vec%0d", i), tbl[i].row, tbl[i].col);
        end
        // line wrap
        pulseClr();
        waitIdle("wrap_clr");
        m = wq.size();
        for (int i = 0; i < 80; i++) begin
            push(8'h41);
            addExp(i, 8'h41);
        end
        addSpaces(80, 80);
        push(8'h42);
        addExp(80, 8'h42);
        waitIdle("wrap");
        checkSeq("wrap", m);
        checkCursor("wrap", 1, 1);
        // bottom wrap
        pulseClr();
        waitIdle("bot_clr");
        for (int i = 0; i < 29; i++) push(8'h0A);
        for (int i = 0; i < 5; i++) push(8'h61);
        waitIdle("bot_pos");
        checkCursor("bot_pos", 29, 5);
        m = wq.size();
        push(8'h0A);
        addSpaces(0, 80);
        waitIdle("bot_lf");
        checkSeq("bot_lf", m);
        checkCursor("bot_lf", 0, 5);
        m = wq.size();
        push(8'h5A);
        addExp(5, 8'h5A);
        waitIdle("bot_z");
        checkSeq("bot_z", m);
        // clear request during a row clear, FIFO non-empty while busy
        m = wq.size();
        push(8'h0A);
        repeat (8) @(negedge clk);
        clr_all = 1'b1;
        push(8'h4D);
        push(8'h4E);
        @(negedge clk);
        clr_all = 1'b0;
        addSpaces(80, 80);
        addSpaces(0, CELLS);
        addExp(0, 8'h4D);
        addExp(1, 8'h4E);
        waitIdle("pend");
        checkSeq("pend", m);
        checkCursor("pend", 0, 2);
        // reset in the middle of a full clear
        pulseClr();
        repeat (100) @(negedge clk);
        check("midclr_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        resetChecks("midrst");
        m = wq.size();
        push(8'h51);
        addExp(0, 8'h51);
        waitIdle("midrst_q");
        checkSeq("midrst_q", m);
        checkCursor("midrst_q", 0, 1);
        // randomized traffic against the screen model
        pulseClr();
        waitIdle("rnd_clr");
        modelClear();
        for (int k = 0; k < 6; k++) begin
            int bad = 0;
            if (k > 0 && $urandom_range(0, 3) == 0) begin
                pulseClr();
                waitIdle("rnd_reclr");
                modelClear();
            end
            m = wq.size();
            expW = 0;
            for (int i = 0; i < 50; i++) begin
                int r;
                logic [7:0] b;
                r = $urandom_range(0, 99);
                b = r < 70 ? 8'($urandom_range(32, 126)) : r < 80 ? 8'h0D : r < 88 ? 8'h0A :
                    r < 96 ? 8'h08 : 8'($urandom_range(0, 255));
                push(b);
                modelByte(b);
            end
            waitIdle($sformatf("rnd%0d", k));
            check($sformatf("rnd%0d_writes", k), wq.size() - m, expW);
            checkCursor($sformatf("rnd%0d", k), mrow, mcol);
            for (int i = 0; i < CELLS; i++)
                if (ram[i] !== 8'(scr[i])) bad++;
            check($sformatf("rnd%0d_screen", k), bad, 0);
        end
        check("protocol", protoErr, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/text_buffer_writer.md
# text_buffer_writer

Consumes received bytes from the UART RX FIFO and writes them into the text-display character RAM that the VGA text renderer scans. Keeps a row/column cursor and interprets CR, LF and BS. Clears each newly entered row, and clears the whole screen on request. Sits between the RX FIFO and the write port of the display's dual-port text buffer; the cursor position is exported for the renderer's cursor glyph.

## Interface
Parameters:
- `COLS`, 80: characters per row (640 px / 8 px font).
- `ROWS`, 30: rows (480 px / 16 px font).
- `ADDR_W`, 12: text RAM address width; must satisfy 2^ADDR_W ≥ COLS*ROWS.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  reset, synchronous, active-low.
- `fifo_empty`  in  1  RX FIFO empty flag.
- `fifo_rd_data`  in  8  FIFO head byte; valid one cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  pop strobe, one cycle per byte.
- `clr_all`  in  1  single-cycle request to clear the screen and home the cursor.
- `wr_en`  out  1  text RAM write strobe.
- `wr_addr`  out  ADDR_W  write address, row*COLS+col.
- `wr_data`  out  8  character code.
- `cur_row`  out  5  cursor row, 0..ROWS-1.
- `cur_col`  out  7  cursor column, 0..COLS-1.
- `busy`  out  1  high in any state other than IDLE.

## Operation
States: IDLE, FETCH, WRITE, CLR_ROW, CLR_ALL.

- **IDLE**
  - If `clr_all` is high: go to CLR_ALL. `clr_all` has priority over the FIFO.
  - Else if `!fifo_empty`: `fifo_rd_en`=1 (combinational from state and flag), go to FETCH.
- **FETCH**: sample `fifo_rd_data` and decode it.
  - 0x20–0x7E (printable): write the char at (row,col).
    - If col<COLS-1: col+1.
    - Else: col=0, row advance, then CLR_ROW.
  - 0x0D (CR): col=0, no write.
  - 0x0A (LF): row advance (col unchanged), then CLR_ROW.
  - 0x08 (BS): if col>0, col-1 and write 0x20 at the new col. At col 0: no-op, no write.
  - Any other code: discarded, no write, cursor unchanged.
- **Row advance**: row+1. From ROWS-1, wraps to 0; there is no scrolling.
- **WRITE**: one cycle.
  - Registered `wr_en`=1 with address/data computed in FETCH.
  - Next state is CLR_ROW if a row advance occurred, else IDLE.
- **CLR_ROW**: writes 0x20 to cols 0..COLS-1 of the new cursor row, one per cycle (COLS cycles), then IDLE. FIFO not read.
- **CLR_ALL**: writes 0x20 to addresses 0..COLS*ROWS-1 sequentially, one per cycle. Cursor set to (0,0) on entry. Then IDLE.
- **clr_all timing**: `clr_all` in any state other than IDLE is latched into a pending flag and serviced on the next IDLE.
- **Address arithmetic**
  - No multiplier: a `row_base` register is kept, +COLS on advance, reset to 0 on wrap.
  - `wr_addr` = `row_base` + col, ADDR_W bits; never exceeds COLS*ROWS-1.

## Timing
- **Reset values**: `fifo_rd_en`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0x00, `cur_row`=0, `cur_col`=0, `busy`=0, state IDLE, pending clear 0.
- **Reset mid-operation**: reset during CLR_ROW/CLR_ALL aborts immediately. The RAM is left partially cleared; no completion is required.
- **Pipeline**: pop at cycle N; decode at N+1; `wr_en` at N+2. The cursor outputs update at N+2, the same cycle as the write.
- **Throughput**:
  - Byte with no row advance: 2 cycles; IDLE may pop again at N+2.
  - Byte with a row advance: 2+COLS cycles.
  - Full clear: COLS*ROWS+1 cycles.
- **FIFO interface**: at most one `fifo_rd_en` per byte. Never asserted while `fifo_empty`=1 or while `busy`=1.
- **Drain rate**: UART delivers 1 byte / ~86.8 µs. A worst-case 82-cycle row clear is far below that, so the 16-entry FIFO never overflows from this block.

## Structure
- **Shared package / header** `text_display_pkg`:
  - COLS, ROWS, ADDR_W.
  - Char constants: CHAR_CR=0x0D, CHAR_LF=0x0A, CHAR_BS=0x08, CHAR_SPACE=0x20.
  - State encoding.
  - These constants are shared with the renderer and the font ROM.
- **Sub-modules**: none required; a single module of FSM plus cursor counters.

## Test plan
1. **Basic text**: reset; push "Hello World!",0x0D,0x0A → 12 writes at addr 0..11 with ASCII codes; cursor ends (1,0); then 80 writes of 0x20 at addr 80..159; `busy` low after.
2. **Line wrap**: push 80 × 'A' → writes at 0..79; the 80th write sets cursor (1,0); then clears 80..159; 81st 'B' written at addr 80.
3. **Backspace**: push 'x',0x08 at (0,0) → write 'x'@0, then 0x20@0, cursor (0,0). A further 0x08 produces no write and no cursor change. Push 0x07 → discarded.
4. **Bottom wrap**: cursor at (29,5), push 0x0A → cursor (29,5)→(0,5), rows cleared at addr 0..79; the next 'Z' is written at addr 5.
5. **clr_all**:
   - `clr_all` pulse during CLR_ROW → serviced after that row finishes.
   - 2400 writes of 0x20 at 0..2399, cursor (0,0).
   - No `fifo_rd_en` while busy, even with the FIFO non-empty.
6. **Reset mid-clear**: `rst_n`=0 for one cycle mid-CLR_ALL → next cycle all outputs at reset values, state IDLE; a following 'Q' is written at addr 0.
